// File: rtl/thresholding_pkg.sv
// ----------------------------------------------------------------------------
// thresholding_pkg
// Shared definitions for the streaming thresholding stage:
//   - default sample and index widths
//   - FSM state encoding
//   - helper giving the width needed to hold |sample| without overflow
// ----------------------------------------------------------------------------
package thresholding_pkg;

    localparam int unsigned W_DEF   = 12;
    localparam int unsigned IDW_DEF = 12;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // |most negative value| needs one extra bit over the sample width.
    function automatic int unsigned abs_width(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/threshold_core.sv
// ----------------------------------------------------------------------------
// threshold_core
// Purely combinational hard/soft thresholding of one signed sample.
// Ports:
//   sig     in  [W-1:0]  signed input sample
//   y_next  out [W-1:0]  thresholded sample
// Parameters:
//   THRESH  threshold magnitude (unsigned)
//   SOFT    0 = hard (pass or zero), 1 = soft (shrink toward zero by THRESH)
// ----------------------------------------------------------------------------
module threshold_core
    import thresholding_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned THRESH = 64,
    parameter int unsigned SOFT   = 0
) (
    input  logic [W-1:0] sig,
    output logic [W-1:0] y_next
);

    localparam int unsigned AW = abs_width(W);
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] TH  = AW'(THRESH);

    logic [AW-1:0] w_sig_ext;
    logic [AW-1:0] w_abs;
    logic [AW-1:0] w_mag;
    logic [AW-1:0] w_soft;
    logic          w_above;
    logic          w_unused_msb;

    always_comb begin
        w_sig_ext = {sig[W-1], sig};
        // Extra bit lets the most negative sample produce a positive magnitude.
        w_abs     = sig[W-1] ? (~w_sig_ext + ONE) : w_sig_ext;
        w_above   = (w_abs > TH);
        w_mag     = w_abs - TH;
        // Sign restore in AW bits; the magnitude always fits W bits once
        // re-signed, including THRESH=0 with the most negative input.
        w_soft    = sig[W-1] ? (~w_mag + ONE) : w_mag;

        y_next = '0;
        if (w_above) begin
            if (SOFT != 0) begin
                y_next = w_soft[W-1:0];
            end else begin
                y_next = sig;
            end
        end
    end

    assign w_unused_msb = w_soft[AW-1];

endmodule

// File: rtl/thresholding.sv
// ----------------------------------------------------------------------------
// thresholding
// Streaming element-wise thresholding stage. A start pulse in IDLE opens a
// frame of exactly N samples, one per clock; each result is registered and
// emitted with a one-cycle valid strobe and its sample index.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   enable  in   start pulse, honoured only in IDLE
//   sig     in   [W-1:0] signed input sample
//   y       out  [W-1:0] registered thresholded sample
//   done    out  output-valid strobe
//   id      out  [IDW-1:0] index of the sample currently on y
// ----------------------------------------------------------------------------
module thresholding
    import thresholding_pkg::*;
#(
    parameter int unsigned N      = 2048,
    parameter int unsigned W      = W_DEF,
    parameter int unsigned IDW    = IDW_DEF,
    parameter int unsigned THRESH = 64,
    parameter int unsigned SOFT   = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [W-1:0]   sig,
    output logic [W-1:0]   y,
    output logic           done,
    output logic [IDW-1:0] id
);

    localparam logic [IDW-1:0] LAST    = IDW'(N - 1);
    localparam logic [IDW-1:0] CNT_ONE = IDW'(1);

    logic           r_state;
    logic [IDW-1:0] r_cnt;
    logic [W-1:0]   r_y;
    logic           r_done;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   w_y_next;

    threshold_core #(
        .W      (W),
        .THRESH (THRESH),
        .SOFT   (SOFT)
    ) u_core (
        .sig    (sig),
        .y_next (w_y_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
            r_id    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // y and id keep the last emitted sample.
                    r_done <= 1'b0;
                    if (enable) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    // enable is ignored here; a frame always runs to N samples.
                    r_y    <= w_y_next;
                    r_done <= 1'b1;
                    r_id   <= r_cnt;
                    if (r_cnt == LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign y    = r_y;
    assign done = r_done;
    assign id   = r_id;

endmodule

// File: tb/tb_thresholding.sv
module tb_thresholding;

    typedef struct packed {
        logic [11:0] y;
        logic [11:0] id;
    } exp_t;

    logic        clk;
    logic        reset;

    logic        en_h, en_s, en_f;
    logic [11:0] sig_h, sig_s, sig_f;
    logic [11:0] y_h, y_s, y_f;
    logic        done_h, done_s, done_f;
    logic [2:0]  id_h, id_s;
    logic [11:0] id_f;

    exp_t q_h[$];
    exp_t q_s[$];
    exp_t q_f[$];

    int n_checks;
    int n_fail;
    int cnt_h, cnt_s, cnt_f;

    thresholding #(.N(8), .W(12), .IDW(3), .THRESH(64), .SOFT(0)) u_hard (
        .clk    (clk),
        .reset  (reset),
        .enable (en_h),
        .sig    (sig_h),
        .y      (y_h),
        .done   (done_h),
        .id     (id_h)
    );

    thresholding #(.N(8), .W(12), .IDW(3), .THRESH(64), .SOFT(1)) u_soft (
        .clk    (clk),
        .reset  (reset),
        .enable (en_s),
        .sig    (sig_s),
        .y      (y_s),
        .done   (done_s),
        .id     (id_s)
    );

    thresholding u_full (
        .clk    (clk),
        .reset  (reset),
        .enable (en_f),
        .sig    (sig_f),
        .y      (y_f),
        .done   (done_f),
        .id     (id_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard-threshold reference at THRESH=64 on plain integers.
    function automatic logic [11:0] hard_ref(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 64) ? 12'(v) : 12'd0;
    endfunction

    // Scoreboard monitors: every done cycle pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done_h === 1'b1) begin
            cnt_h++;
            n_checks++;
            if (q_h.size() == 0) begin
                n_fail++;
                $display("FAIL hard_unexpected_done: y=%0d id=%0d with empty scoreboard",
                         $signed(y_h), id_h);
            end else begin
                e = q_h.pop_front();
                if (y_h !== e.y || {9'd0, id_h} !== e.id) begin
                    n_fail++;
                    $display("FAIL hard_out: got y=%0d id=%0d, expected y=%0d id=%0d",
                             $signed(y_h), id_h, $signed(e.y), e.id);
                end
            end
        end
        if (done_s === 1'b1) begin
            cnt_s++;
            n_checks++;
            if (q_s.size() == 0) begin
                n_fail++;
                $display("FAIL soft_unexpected_done: y=%0d id=%0d with empty scoreboard",
                         $signed(y_s), id_s);
            end else begin
                e = q_s.pop_front();
                if (y_s !== e.y || {9'd0, id_s} !== e.id) begin
                    n_fail++;
                    $display("FAIL soft_out: got y=%0d id=%0d, expected y=%0d id=%0d",
                             $signed(y_s), id_s, $signed(e.y), e.id);
                end
            end
        end
        if (done_f === 1'b1) begin
            cnt_f++;
            n_checks++;
            if (q_f.size() == 0) begin
                n_fail++;
                $display("FAIL full_unexpected_done: y=%0d id=%0d with empty scoreboard",
                         $signed(y_f), id_f);
            end else begin
                e = q_f.pop_front();
                if (y_f !== e.y || id_f !== e.id) begin
                    n_fail++;
                    $display("FAIL full_out: got y=%0d id=%0d, expected y=%0d id=%0d",
                             $signed(y_f), id_f, $signed(e.y), e.id);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en_h = 1'b0; en_s = 1'b0; en_f = 1'b0;
        sig_h = '0; sig_s = '0; sig_f = '0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (y_h !== 12'd0 || done_h !== 1'b0 || id_h !== 3'd0 ||
                y_s !== 12'd0 || done_s !== 1'b0 || id_s !== 3'd0 ||
                y_f !== 12'd0 || done_f !== 1'b0 || id_f !== 12'd0) begin
                n_fail++;
                $display("FAIL reset_idle: cycle %0d done=%b/%b/%b y=%0d/%0d/%0d, expected all 0",
                         i, done_h, done_s, done_f, y_h, y_s, y_f);
            end
        end
        step();
    endtask

    task automatic test_hard_frame();
        int sv[8] = '{100, -100, 64, -64, 65, 0, -2048, 2047};
        int ev[8] = '{100, -100, 0, 0, 65, 0, -2048, 2047};
        exp_t e;
        cnt_h = 0;
        en_h = 1'b1;
        step();
        en_h = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sig_h = 12'(sv[i]);
            e.y = 12'(ev[i]);
            e.id = 12'(i);
            q_h.push_back(e);
            step();
        end
        step();
        n_checks++;
        if (cnt_h != 8 || q_h.size() != 0) begin
            n_fail++;
            $display("FAIL hard_frame_count: done cycles=%0d left=%0d, expected 8 and 0",
                     cnt_h, q_h.size());
        end
        n_checks++;
        if (done_h !== 1'b0 || y_h !== 12'h7FF || id_h !== 3'd7) begin
            n_fail++;
            $display("FAIL hard_idle_hold: done=%b y=%0d id=%0d, expected 0 2047 7",
                     done_h, $signed(y_h), id_h);
        end
    endtask

    task automatic test_soft_frame();
        int sv[8] = '{100, -100, 64, -2048, 65, -65, 2047, 0};
        int ev[8] = '{36, -36, 0, -1984, 1, -1, 1983, 0};
        exp_t e;
        cnt_s = 0;
        en_s = 1'b1;
        step();
        en_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sig_s = 12'(sv[i]);
            e.y = 12'(ev[i]);
            e.id = 12'(i);
            q_s.push_back(e);
            step();
        end
        step();
        n_checks++;
        if (cnt_s != 8 || q_s.size() != 0 || done_s !== 1'b0) begin
            n_fail++;
            $display("FAIL soft_frame_count: done cycles=%0d left=%0d done=%b, expected 8 0 0",
                     cnt_s, q_s.size(), done_s);
        end
    endtask

    task automatic test_reenable();
        exp_t e;
        int v;
        cnt_h = 0;
        en_h = 1'b1;
        step();
        en_h = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(4095)) - 2048;
            sig_h = 12'(v);
            en_h = (i == 3);
            e.y = hard_ref(v);
            e.id = 12'(i);
            q_h.push_back(e);
            step();
        end
        // Pulse on the edge right after the last capture starts a new frame.
        en_h = 1'b1;
        step();
        en_h = 1'b0;
        n_checks++;
        if (cnt_h != 8 || done_h !== 1'b0) begin
            n_fail++;
            $display("FAIL reenable_first_frame: done cycles=%0d done=%b, expected 8 0",
                     cnt_h, done_h);
        end
        for (int i = 0; i < 8; i++) begin
            v = (i * 300) - 1100;
            sig_h = 12'(v);
            e.y = hard_ref(v);
            e.id = 12'(i);
            q_h.push_back(e);
            step();
        end
        step();
        n_checks++;
        if (cnt_h != 16 || q_h.size() != 0 || done_h !== 1'b0) begin
            n_fail++;
            $display("FAIL reenable_second_frame: done cycles=%0d left=%0d done=%b, expected 16 0 0",
                     cnt_h, q_h.size(), done_h);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        int v;
        cnt_h = 0;
        en_h = 1'b1;
        step();
        en_h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 500 + i;
            sig_h = 12'(v);
            e.y = hard_ref(v);
            e.id = 12'(i);
            q_h.push_back(e);
            step();
        end
        sig_h = 12'(700);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (y_h !== 12'd0 || done_h !== 1'b0 || id_h !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: y=%0d done=%b id=%0d, expected 0 0 0",
                     $signed(y_h), done_h, id_h);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (done_h !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_no_resume: cycle %0d done=%b, expected 0", i, done_h);
            end
        end
        n_checks++;
        if (cnt_h != 4 || q_h.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_count: done cycles=%0d left=%0d, expected 4 0",
                     cnt_h, q_h.size());
        end
    endtask

    task automatic test_full_frame();
        exp_t e;
        int v;
        cnt_f = 0;
        en_f = 1'b1;
        step();
        en_f = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            v = i - 1024;
            sig_f = 12'(v);
            e.y = hard_ref(v);
            e.id = 12'(i);
            q_f.push_back(e);
            step();
        end
        step();
        n_checks++;
        if (cnt_f != 2048 || q_f.size() != 0 || done_f !== 1'b0) begin
            n_fail++;
            $display("FAIL full_frame_count: done cycles=%0d left=%0d done=%b, expected 2048 0 0",
                     cnt_f, q_f.size(), done_f);
        end
        n_checks++;
        if (id_f !== 12'd2047 || y_f !== 12'd1023) begin
            n_fail++;
            $display("FAIL full_frame_last: id=%0d y=%0d, expected 2047 1023",
                     id_f, $signed(y_f));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cnt_h = 0;
        cnt_s = 0;
        cnt_f = 0;
        test_reset();
        test_hard_frame();
        test_soft_frame();
        test_reenable();
        test_reset_mid_frame();
        test_full_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/thresholding.md
Name: thresholding

Overview:
- Streaming element-wise thresholding stage for the compressed-sensing ECG path.
- After a one-cycle start pulse, accepts exactly N signed samples, one per clock.
- Each sample goes through hard or soft thresholding. The result is emitted with a valid strobe and its sample index.
- Sits between the sample source (ECG word memory/ADC stream) and the sparse-coefficient consumer.

Parameters:
- N, 2048, number of samples per frame.
- W, 12, sample/result width (signed two's complement).
- IDW, 12, index width; must satisfy 2^IDW >= N.
- THRESH, 64, threshold magnitude, unsigned, 0 <= THRESH <= 2047.
- SOFT, 0, 0 = hard thresholding, 1 = soft thresholding.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start pulse; sampled high in IDLE begins a frame.
- sig  in  W signed  input sample; must be stable before each capture edge.
- y  out  W signed  thresholded sample, registered.
- done  out  1  output-valid strobe; high for exactly one cycle per emitted sample.
- id  out  IDW  index (0..N-1) of the sample currently on y.

Behaviour:
- Reset (reset=0, async): state=IDLE, y=0, done=0, id=0, sample counter=0.
- States:
  - IDLE: done=0, y and id hold their last values. On a rising edge with enable=1, go to RUN and clear the counter. That edge captures no sample.
  - RUN: on every rising edge, capture sig and register the result: y=f(sig), done=1, id=counter; then counter++. The edge that captures sample N-1 moves to IDLE.
  - On the first IDLE edge after that, done returns to 0.
- Timing: if enable is seen high at edge E0, samples are captured at E1..EN. Outputs for the sample captured at Ei are visible from Ei until Ei+1.
  - Latency is one register stage: sig presented in cycle i appears on y in cycle i+1.
  - done is high continuously for N cycles, then drops.
- enable while in RUN is ignored; the frame is not restarted and the counter is unaffected.
- enable held high: one frame runs. A new frame starts on the first IDLE edge where enable=1, which can be the edge immediately after the last capture.
- Reset asserted mid-frame aborts immediately: IDLE, outputs cleared. No partial-frame completion after reset releases.
- Arithmetic: a=|sig| computed in W+1 bits, so -2048 gives 2048.
  - Hard (SOFT=0): y = sig if a > THRESH, else 0. Exactly equal to THRESH gives 0. -2048 passes unchanged.
  - Soft (SOFT=1): y = 0 if a <= THRESH, else sign(sig)*(a-THRESH), computed in W+1 bits. The result magnitude is at most 2048-THRESH. If THRESH=0 and sig=-2048, y=-2048 (no overflow); otherwise the value is truncated to W bits without loss.
- THRESH=0, hard mode: every nonzero sample passes; 0 gives 0.
- The counter wraps only by frame end. It never exceeds N-1 on id.

Decomposition:
- Shared package thresholding_pkg holds:
  - the W/IDW defaults;
  - the state encoding (IDLE=1'b0, RUN=1'b1);
  - a function or constant for the sample-type width.
- Sub-module threshold_core: purely combinational. Inputs sig[W] and THRESH/SOFT parameters; output y_next[W]. Implements the abs/compare/subtract/sign-restore.
- The top level holds the FSM, counter and output registers.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, enable=0 for 10 cycles -> y=0, done=0, id=0 throughout.
- Basic frame, hard mode, THRESH=64, N=8: enable pulse, then sig sequence 100,-100,64,-64,65,0,-2048,2047 -> done high for 8 consecutive cycles starting one cycle after the first sample. y = 100,-100,0,0,65,0,-2048,2047; id = 0..7; done low afterwards.
- Soft mode, SOFT=1, THRESH=64: sig 100,-100,64,-2048,65 -> y = 36,-36,0,-1984,1.
- enable re-pulsed mid-frame (N=8, pulse during sample 3) -> ids still 0..7 with no restart, exactly 8 done cycles. A pulse on the edge after the last capture starts a new frame with id=0.
- Reset mid-frame: assert reset during sample 4 of 8 -> y/done/id go to 0 immediately (async). After release with no enable, done stays 0.
- Full default frame N=2048, stimulus ramp sig=i-1024 -> 2048 done cycles, id=0..2047. y=0 exactly for |i-1024| <= 64, else equal to sig.
